adrv9001_axis_capture: RTL and testbench
========================================

# adrv9001_axis_capture

Parametrised in-fabric capture engine for the ADRV9001 AXI-Stream sample path and its control/DGPIO sidebands. It records qualified beats (tvalid & tready) into a circular buffer with a programmable pre-trigger window and a masked pattern trigger (level or rising-edge), then freezes the buffer. A simple synchronous read port returns the samples in time order. Inputs are already in clk's domain; upstream CDC stays outside this block.

## Interface
- DATA_WIDTH, 32: width of s_axis_tdata.
- SIDE_WIDTH, 16: width of sideband probe word (DGPIO monitor, enables).
- ADDR_WIDTH, 10: buffer depth = 2**ADDR_WIDTH entries of DATA_WIDTH+SIDE_WIDTH bits.

Ports:
- clk  in  1  capture clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  monitored stream data (passive tap).
- s_axis_tvalid  in  1  monitored valid.
- s_axis_tready  in  1  monitored ready (input; block never drives it).
- side_in  in  SIDE_WIDTH  sideband word stored with each beat and used as trigger source.
- arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE.
- abort  in  1  single-cycle pulse; returns to IDLE, done cleared.
- trig_edge  in  1  0 = level trigger, 1 = rising-edge trigger.
- trig_mask  in  SIDE_WIDTH  bits participating in comparison.
- trig_value  in  SIDE_WIDTH  required value of masked bits.
- trig_force  in  1  pulse; acts as a trigger when armed.
- pre_trig  in  ADDR_WIDTH  number of pre-trigger beats; sampled on arm.
- armed  out  1  high in PRE and WAIT.
- triggered  out  1  high in POST and DONE.
- done  out  1  high in DONE.
- rd_addr  in  ADDR_WIDTH  time-ordered index (0 = oldest sample).
- rd_data  out  DATA_WIDTH+SIDE_WIDTH  {side, data} at rd_addr; 1-cycle latency.

## Operation
- Qualified beat q = s_axis_tvalid & s_axis_tready. Only q beats are written and counted.
- Match m = ((side_in ^ trig_value) & trig_mask) == 0. An all-zero mask gives m = 1.
- Level mode: hit = m & q. Edge mode: hit = m & ~m_prev & q, where m_prev updates on q beats only and clears on arm.
- trig_force counts as a hit even without q.
- States:
  - IDLE: nothing written. arm → PRE. pre_trig latched as P, wr_ptr and fill counter cleared.
  - PRE: write on q. When fill == P (immediately if P == 0) → WAIT. Hits in PRE are ignored.
  - WAIT: write on q, wrapping freely. On hit: the triggering beat (if q) is written, trig_ptr is latched, post counter = DEPTH−P−1 → POST.
  - POST: write on q, decrement post counter. At 0 → DONE. The counter-0 write is the last write; when DEPTH−P−1 = 0 that is the trigger beat itself.
  - DONE: no writes. start_ptr = trig_ptr − P (mod DEPTH), frozen. arm → PRE (new capture).
- abort in any state → IDLE. Buffer contents are retained; done, triggered and armed are cleared.
- Simultaneous arm and abort: abort wins. arm while in PRE, WAIT or POST is ignored.
- Readback: physical address = start_ptr + rd_addr (mod DEPTH). Valid only in DONE. Outside DONE, rd_data is unspecified but stable.
- Pointer arithmetic is ADDR_WIDTH bits, natural wrap-around. Counters never exceed DEPTH−1.

## Timing
- Reset values: armed = 0, triggered = 0, done = 0, rd_data = 0, state = IDLE, all pointers and counters = 0, m_prev = 0.
- A q beat at cycle n is written at edge n (RAM write registered).
- Trigger state change takes effect at the edge of the hit cycle. triggered is high from cycle n+1.
- done rises the cycle after the final POST write.
- rd_data reflects rd_addr presented one cycle earlier (registered RAM read).
- Status outputs are registered decodes of state.

## Structure
- Package adrv9001_capture_pkg holds:
  - the state enum (IDLE, PRE, WAIT, POST, DONE);
  - the default ADDR_WIDTH and SIDE_WIDTH constants.
- Sub-module adrv9001_capture_ram: simple dual-port, one write port and one registered read port on clk, width DATA_WIDTH+SIDE_WIDTH, inferable as BRAM.
- Top holds the FSM, trigger compare, pointers and read-address offset adder.

## Test plan
- ADDR_WIDTH = 4, P = 4, continuous q with data = beat index. Hit at index 20 → done. rd_addr 0..15 returns 16..31, and rd_addr 4 = 20.
- P = 0, edge mode, mask = 0x0001, value = 1, side[0] held high from arm → no trigger. A 0→1 transition at beat 9 → rd_addr 0 = 9.
- Hit during PRE (beat 2, P = 4) is ignored. A later hit at beat 7 triggers, and rd_addr 4 = 7.
- tvalid toggling 50% with tready = 1: only qualified beats are stored and counted; gaps do not advance post counter.
- abort mid-POST → armed = triggered = done = 0 next cycle. A subsequent arm+trig_force completes a normal capture.
- rst asserted in WAIT → all outputs at reset values next cycle. arm+abort in the same cycle → stays IDLE.

Source files
------------

// File: rtl/adrv9001_capture_pkg.sv
// Shared definitions for the ADRV9001 AXI-Stream capture engine.
//   cap_state_t        : capture FSM states
//   DEFAULT_ADDR_WIDTH : default buffer address width (depth = 2**ADDR_WIDTH)
//   DEFAULT_SIDE_WIDTH : default sideband probe word width
package adrv9001_capture_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_SIDE_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } cap_state_t;

endpackage

// File: rtl/adrv9001_capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port,
// both on clk. Written so that synthesis maps it onto block RAM.
//   clk     : clock
//   rst     : synchronous active-high reset (read output register only)
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data, one cycle after rd_addr
module adrv9001_capture_ram #(
    parameter int WIDTH      = 48,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adrv9001_axis_capture.sv
// Capture engine for the ADRV9001 AXI-Stream sample path. Records qualified
// beats (tvalid & tready) with their sideband word into a circular buffer,
// keeps a programmable pre-trigger window, triggers on a masked sideband
// pattern (level or rising edge) or a forced pulse, then freezes the buffer.
// Readback is time ordered: rd_addr 0 is the oldest kept sample.
//   clk, rst            : clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready : passive stream tap
//   side_in             : sideband word, stored and used as trigger source
//   arm, abort          : start capture / return to idle (pulses)
//   trig_edge, trig_mask, trig_value, trig_force : trigger setup
//   pre_trig            : pre-trigger beat count, sampled on arm
//   armed, triggered, done : registered status
//   rd_addr, rd_data    : time-ordered read port, 1-cycle latency
//
// state | meaning
// IDLE  | no capture, nothing written
// PRE   | filling the pre-trigger window, hits ignored
// WAIT  | free-running circular writes, looking for a hit
// POST  | writing the post-trigger beats
// DONE  | buffer frozen, readback valid
module adrv9001_axis_capture
    import adrv9001_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIDE_WIDTH = DEFAULT_SIDE_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tready,
    input  logic [SIDE_WIDTH-1:0]            side_in,
    input  logic                             arm,
    input  logic                             abort,
    input  logic                             trig_edge,
    input  logic [SIDE_WIDTH-1:0]            trig_mask,
    input  logic [SIDE_WIDTH-1:0]            trig_value,
    input  logic                             trig_force,
    input  logic [ADDR_WIDTH-1:0]            pre_trig,
    output logic                             armed,
    output logic                             triggered,
    output logic                             done,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH+SIDE_WIDTH-1:0] rd_data
);

    cap_state_t            state;
    cap_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill;
    logic [ADDR_WIDTH-1:0] fill_inc;
    logic [ADDR_WIDTH-1:0] p_len;
    logic [ADDR_WIDTH-1:0] trig_ptr;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH-1:0] post_init;
    logic [ADDR_WIDTH-1:0] start_ptr;
    logic [ADDR_WIDTH-1:0] trig_ptr_eff;
    logic                  m_prev;
    logic                  q;
    logic                  m;
    logic                  hit;
    logic                  arm_go;
    logic                  we;

    assign q        = s_axis_tvalid & s_axis_tready;
    assign m        = ((side_in ^ trig_value) & trig_mask) == '0;
    assign hit      = trig_force | (m & q & (~trig_edge | ~m_prev));
    assign arm_go   = arm & ~abort & ((state == ST_IDLE) || (state == ST_DONE));
    assign fill_inc = fill + {{(ADDR_WIDTH-1){1'b0}}, q};
    // DEPTH-1-P without leaving ADDR_WIDTH bits: all-ones minus P.
    assign post_init = {ADDR_WIDTH{1'b1}} - p_len;
    assign we = q & ((state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST));
    // When the trigger lands with no post beats to take, trig_ptr has not
    // been latched yet, so the live write pointer is used for start_ptr.
    assign trig_ptr_eff = (state == ST_WAIT) ? wr_ptr : trig_ptr;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) state_nxt = ST_PRE;
            end
            ST_PRE: begin
                // fill == p_len covers P = 0, fill_inc covers the P-th beat.
                if ((fill == p_len) || (fill_inc == p_len)) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (hit) state_nxt = (post_init == '0) ? ST_DONE : ST_POST;
            end
            ST_POST: begin
                if (q && (post_cnt == ADDR_WIDTH'(1))) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            wr_ptr    <= '0;
            fill      <= '0;
            p_len     <= '0;
            trig_ptr  <= '0;
            post_cnt  <= '0;
            start_ptr <= '0;
            m_prev    <= 1'b0;
        end else begin
            state     <= state_nxt;
            armed     <= (state_nxt == ST_PRE) || (state_nxt == ST_WAIT);
            triggered <= (state_nxt == ST_POST) || (state_nxt == ST_DONE);
            done      <= (state_nxt == ST_DONE);

            if (we) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if ((state == ST_PRE) && q) fill <= fill_inc;

            if ((state == ST_WAIT) && hit) begin
                trig_ptr <= wr_ptr;
                post_cnt <= post_init;
            end else if ((state == ST_POST) && q) begin
                post_cnt <= post_cnt - ADDR_WIDTH'(1);
            end

            if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
                start_ptr <= trig_ptr_eff - p_len;
            end

            if (q) m_prev <= m;

            if (arm_go) begin
                p_len  <= pre_trig;
                wr_ptr <= '0;
                fill   <= '0;
                m_prev <= 1'b0;
            end
        end
    end

    logic [ADDR_WIDTH-1:0] rd_phys;
    assign rd_phys = start_ptr + rd_addr;

    adrv9001_capture_ram #(
        .WIDTH      (DATA_WIDTH + SIDE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data ({side_in, s_axis_tdata}),
        .rd_addr (rd_phys),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_adrv9001_axis_capture.sv
module tb_adrv9001_axis_capture;

    localparam int DW    = 32;
    localparam int SW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int WW    = DW + SW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [SW-1:0] side_in;
    logic          arm;
    logic          abort;
    logic          trig_edge;
    logic [SW-1:0] trig_mask;
    logic [SW-1:0] trig_value;
    logic          trig_force;
    logic [AW-1:0] pre_trig;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] plan_side [0:511];

    adrv9001_axis_capture #(
        .DATA_WIDTH (DW),
        .SIDE_WIDTH (SW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .side_in       (side_in),
        .arm           (arm),
        .abort         (abort),
        .trig_edge     (trig_edge),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .trig_force    (trig_force),
        .pre_trig      (pre_trig),
        .armed         (armed),
        .triggered     (triggered),
        .done          (done),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        side_in       = '0;
        arm           = 1'b0;
        abort         = 1'b0;
        trig_force    = 1'b0;
    endtask

    // Reference: beats are numbered from 0 after arm. A beat is a hit when it
    // is forced or its masked sideband matches (edge mode: and the previous
    // beat did not). The first pre_trig beats (at least one when P = 0, the
    // beat seen while the window opens) belong to the pre-trigger window.
    function automatic int model_trigger(input int p, input bit edge_mode,
                                         input logic [SW-1:0] mask,
                                         input logic [SW-1:0] value,
                                         input int force_beat);
        bit m_cur;
        bit m_last;
        bit is_hit;
        int first_ok;
        first_ok = (p == 0) ? 1 : p;
        m_last = 1'b0;
        for (int k = 0; k < 400; k++) begin
            m_cur  = ((plan_side[k] ^ value) & mask) == '0;
            is_hit = (k == force_beat) || (edge_mode ? (m_cur && !m_last) : m_cur);
            if (is_hit && k >= first_ok) return k;
            m_last = m_cur;
        end
        return -1;
    endfunction

    task automatic run_capture(input string name, input int p, input bit edge_mode,
                               input logic [SW-1:0] mask, input logic [SW-1:0] value,
                               input int force_beat, input int valid_pct,
                               input int abort_beat);
        int t;
        int k;
        bit got_done;
        bit v;
        int sel;
        logic [WW-1:0] exp_w;
        t = model_trigger(p, edge_mode, mask, value, force_beat);
        trig_edge  = edge_mode;
        trig_mask  = mask;
        trig_value = value;
        pre_trig   = AW'(p);
        arm = 1'b1;
        step();
        arm = 1'b0;
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL %s armed_after_arm: got %b expected 1", name, armed);
        end
        k = 0;
        got_done = 1'b0;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            v = int'($urandom_range(99)) < valid_pct;
            if (v) begin
                s_axis_tvalid = 1'b1;
                s_axis_tready = 1'b1;
                side_in       = plan_side[k];
            end else begin
                sel = int'($urandom_range(2));
                s_axis_tvalid = (sel == 1);
                s_axis_tready = (sel == 2);
                side_in       = SW'($urandom);
            end
            s_axis_tdata = DW'(k);
            trig_force   = v && (k == force_beat);
            abort        = v && (k == abort_beat);
            step();
            if (v) begin
                if (abort) begin
                    idle_inputs();
                    checks++;
                    if ({armed, triggered, done} !== 3'b000) begin
                        errors++;
                        $display("FAIL %s status_after_abort: got %b expected 000", name,
                                 {armed, triggered, done});
                    end
                    return;
                end
                if (k == t - 1) begin
                    checks++;
                    if (triggered !== 1'b0) begin
                        errors++;
                        $display("FAIL %s triggered_early: got %b expected 0", name, triggered);
                    end
                end
                if (k == t) begin
                    checks++;
                    if (triggered !== 1'b1) begin
                        errors++;
                        $display("FAIL %s triggered_after_hit: got %b expected 1", name, triggered);
                    end
                end
                k++;
            end
            if (done === 1'b1) got_done = 1'b1;
        end
        idle_inputs();
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s done_timeout: got done=%b expected 1 within 2000 cycles", name, done);
            return;
        end
        checks++;
        if (k != t + DEPTH - p) begin
            errors++;
            $display("FAIL %s beats_at_done: got %0d expected %0d", name, k, t + DEPTH - p);
        end
        checks++;
        if ({armed, triggered} !== 2'b01) begin
            errors++;
            $display("FAIL %s status_in_done: got armed=%b triggered=%b expected 0 1", name,
                     armed, triggered);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            step();
            exp_w = {plan_side[t - p + i], DW'(t - p + i)};
            checks++;
            if (rd_data !== exp_w) begin
                errors++;
                $display("FAIL %s rd_data[%0d]: got %h expected %h", name, i, rd_data, exp_w);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        trig_edge = 1'b0; trig_mask = '0; trig_value = '0; pre_trig = '0; rd_addr = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({armed, triggered, done} !== 3'b000 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got status=%b rd_data=%h expected 000 and 0",
                     {armed, triggered, done}, rd_data);
        end
    endtask

    task automatic test_level_basic();
        for (int k = 0; k < 512; k++) plan_side[k] = SW'(k);
        run_capture("level_basic", 4, 1'b0, 16'h00FF, 16'h0014, -1, 100, -1);
    endtask

    task automatic test_edge_p0();
        for (int k = 0; k < 512; k++)
            plan_side[k] = {15'($urandom), ((k < 6) || (k >= 9)) ? 1'b1 : 1'b0};
        run_capture("edge_p0", 0, 1'b1, 16'h0001, 16'h0001, -1, 100, -1);
    endtask

    task automatic test_pre_hit_ignored();
        for (int k = 0; k < 512; k++)
            plan_side[k] = ((k == 2) || (k == 7)) ? 16'h1234 : SW'(16'h4000 + k);
        run_capture("pre_hit_ignored", 4, 1'b0, 16'hFFFF, 16'h1234, -1, 100, -1);
    endtask

    task automatic test_gaps();
        logic [SW-1:0] s;
        for (int k = 0; k < 512; k++) begin
            s = SW'($urandom);
            if (s[7:4] == 4'hA) s[7:4] = 4'h5;
            if ((k == 1) || (k == 12)) s[7:4] = 4'hA;
            plan_side[k] = s;
        end
        run_capture("gaps", 3, 1'b0, 16'h00F0, 16'h00A0, -1, 50, -1);
    endtask

    task automatic test_abort();
        for (int k = 0; k < 512; k++) plan_side[k] = (k == 5) ? 16'h5555 : SW'(k);
        run_capture("abort_post", 2, 1'b0, 16'hFFFF, 16'h5555, -1, 100, 9);
        step();
        for (int k = 0; k < 512; k++) plan_side[k] = SW'(k);
        run_capture("force_after_abort", 1, 1'b0, 16'hFFFF, 16'hFFFF, 6, 100, -1);
    endtask

    task automatic test_rst_in_wait();
        trig_edge = 1'b0; trig_mask = 16'hFFFF; trig_value = 16'hFFFF; pre_trig = '0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tready = 1'b1;
            s_axis_tdata = DW'(k); side_in = SW'(k);
            step();
        end
        idle_inputs();
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_wait armed_before_rst: got %b expected 1", armed);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({armed, triggered, done} !== 3'b000 || rd_data !== '0) begin
            errors++;
            $display("FAIL rst_in_wait reset_values: got status=%b rd_data=%h expected 000 and 0",
                     {armed, triggered, done}, rd_data);
        end
    endtask

    task automatic test_arm_abort();
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort armed: got %b expected 0", armed);
        end
        step();
        checks++;
        if ({armed, done} !== 2'b00) begin
            errors++;
            $display("FAIL arm_abort stays_idle: got armed=%b done=%b expected 0 0", armed, done);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_level_basic();
        test_edge_p0();
        test_pre_hit_ignored();
        test_gaps();
        test_abort();
        test_rst_in_wait();
        test_arm_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
